// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_e;

  localparam int ADDR_W_DEF      = 10;
  localparam int NUM_BLOCKS_DEF  = 8;
  localparam int BLOCK_WORDS_DEF = 4;

  localparam int IDX_W   = $clog2(NUM_BLOCKS_DEF);
  localparam int OFF_W   = $clog2(BLOCK_WORDS_DEF);
  localparam int TAG_W   = ADDR_W_DEF - 2 - OFF_W - IDX_W;
  localparam int BLOCK_W = 32 * BLOCK_WORDS_DEF;

  // PC value the PC register holds while in reset: means "nothing to fetch".
  localparam logic [31:0] NO_FETCH_PC = 32'hFFFF_FFFC;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the instruction cache; one write port, one combinational read port.
module icache_line_store #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 3,
  parameter int BLOCK_W    = 128
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   widx_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [BLOCK_W-1:0] wblock_i,
  input  logic [IDX_W-1:0]   ridx_i,
  output logic               rvalid_o,
  output logic [TAG_W-1:0]   rtag_o,
  output logic [BLOCK_W-1:0] rblock_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tags and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wblock_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rblock_o = data_q[ridx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with block refill FSM.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                     CLK,
  input  logic                                     RESET_N,
  input  logic [31:0]                              PC,
  output logic [31:0]                              INSTRUCTION,
  output logic                                     BUSYWAIT,
  output logic                                     MEM_READ,
  output logic [ADDR_W-3-$clog2(BLOCK_WORDS):0]    MEM_ADDRESS,
  input  logic [32*BLOCK_WORDS-1:0]                MEM_READDATA,
  input  logic                                     MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                              HIT_COUNT,
  output logic [15:0]                              MISS_COUNT
`endif
);

  localparam int OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int IDX_BITS = $clog2(NUM_BLOCKS);
  localparam int TAG_BITS = ADDR_W - 2 - OFF_BITS - IDX_BITS;
  localparam int BLK_BITS = 32 * BLOCK_WORDS;

  logic [OFF_BITS-1:0] pc_off;
  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic                no_fetch;

  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [BLK_BITS-1:0] line_block;
  logic [31:0]         words [BLOCK_WORDS];
  logic                hit;
  logic                line_we;

  state_e              state_q;
  logic                mem_read_q;
  logic [BLK_BITS-1:0] block_q;

  assign pc_off   = PC[2 +: OFF_BITS];
  assign pc_idx   = PC[2+OFF_BITS +: IDX_BITS];
  assign pc_tag   = PC[2+OFF_BITS+IDX_BITS +: TAG_BITS];
  assign no_fetch = (PC == NO_FETCH_PC);

  icache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_BITS),
    .TAG_W      (TAG_BITS),
    .BLOCK_W    (BLK_BITS)
  ) u_store (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .we_i     (line_we),
    .widx_i   (pc_idx),
    .wtag_i   (pc_tag),
    .wblock_i (block_q),
    .ridx_i   (pc_idx),
    .rvalid_o (line_valid),
    .rtag_o   (line_tag),
    .rblock_o (line_block)
  );

  assign hit = line_valid && (line_tag == pc_tag);

  always_comb begin
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      words[w] = line_block[32*w +: 32];
    end
  end

  assign INSTRUCTION = words[pc_off];

  // Stall is combinational on a miss in IDLE so the PC freezes in the same cycle.
  assign BUSYWAIT    = (state_q != IDLE) || (!hit && !no_fetch);
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = PC[ADDR_W-1:2+OFF_BITS];

  // PC is frozen during the miss, so its index/tag still address the line being refilled.
  assign line_we = RESET_N && (state_q == UPDATE);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit && !no_fetch) begin
            state_q    <= icache_pkg::MEM_READ;
            mem_read_q <= 1'b1;
          end
        end
        icache_pkg::MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory data is only guaranteed in the cycle MEM_BUSYWAIT falls, so hold it for UPDATE.
  always_ff @(posedge CLK) begin
    if ((state_q == icache_pkg::MEM_READ) && !MEM_BUSYWAIT) begin
      block_q <= MEM_READDATA;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && !no_fetch) begin
      if (hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if (!hit && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
